prog_loader: RTL and testbench

- Byte-serial program loader that writes instruction words into the CPU's instruction/data memory, then releases the CPU from reset.
- It is the writer side of the memory the CPU fetch stage reads: a host streams a length header and big-endian instruction words, and the block issues single-cycle memory writes.
- It sits between the host byte link and the memory write port, and drives the CPU's reset.

---
 rtl/prog_loader.sv | 192 +++++++++++++++++++
 tb/tb_prog_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-serial program loader: length header + big-endian words -> memory writes, then CPU release.
// Optional trailer checksum (running XOR of data bytes) enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int WIDTH     = 32,
    parameter int ADDRSIZE  = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    output logic                mem_we,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                cpu_rst_n,
    output logic [ADDRSIZE:0]   words_loaded
);
    localparam int BYTES = WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam longint unsigned MEMSIZE = 64'd1 << ADDRSIZE;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR, S_CHK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [WIDTH-1:0]    asm_q, asm_d;
    logic [BCW-1:0]      byte_cnt_q, byte_cnt_d;
    logic [ADDRSIZE-1:0] index_q, index_d;
    logic [ADDRSIZE:0]   words_q, words_d;
    logic [ADDRSIZE-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]          xor_q, xor_d;
`endif

    logic        accept;
    logic [15:0] len_full;
    logic        last_word;

    assign len_full  = {len_q[15:8], rx_data};
    assign last_word = (32'(index_q) + 32'd1) == 32'(len_q);

    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA: begin rx_ready = 1'b1; busy = 1'b1; end
            S_WRITE:                    busy = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK:                      begin rx_ready = 1'b1; busy = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign accept       = rx_valid && rx_ready;
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);
    assign cpu_rst_n    = (state_q == S_DONE);
    assign mem_we       = (state_q == S_WRITE);
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign words_loaded = words_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        asm_d      = asm_q;
        byte_cnt_d = byte_cnt_q;
        index_d    = index_q;
        words_d    = words_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_start) begin
                    state_d    = S_LEN_HI;
                    words_d    = '0;
                    index_d    = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    xor_d      = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else if (64'(len_full) > MEMSIZE) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_d = WIDTH'({asm_q, rx_data});
`ifdef PROG_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ rx_data;
`endif
                    // Write port is latched here so it holds steady after WRITE.
                    if (byte_cnt_q == BCW'(BYTES - 1)) begin
                        byte_cnt_d = '0;
                        wdata_d    = asm_d;
                        addr_d     = ADDRSIZE'(32'(BASE_ADDR) + 32'(index_q));
                        state_d    = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
            end
            S_WRITE: begin
                words_d = words_q + 1'b1;
                if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = S_DATA;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            asm_q      <= '0;
            byte_cnt_q <= '0;
            index_q    <= '0;
            words_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_d;
            index_q    <= index_d;
            words_q    <= words_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (BASE_ADDR 0 and 0xFFF) share one byte stream and are
// checked against a write scoreboard; define PROG_LOADER_CHECKSUM_EN to exercise the trailer.
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;

    logic        rx_ready_a, mem_we_a, busy_a, done_a, error_a, cpu_rst_n_a;
    logic [11:0] mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic [12:0] words_loaded_a;
    logic        rx_ready_b, mem_we_b, busy_b, done_b, error_b, cpu_rst_n_b;
    logic [11:0] mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [12:0] words_loaded_b;

    prog_loader #(.WIDTH(32), .ADDRSIZE(12), .BASE_ADDR(0)) dut_a (
        .clk(clk), .reset(reset), .load_start(load_start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_we(mem_we_a), .busy(busy_a), .done(done_a),
        .error(error_a), .cpu_rst_n(cpu_rst_n_a), .words_loaded(words_loaded_a));

    prog_loader #(.WIDTH(32), .ADDRSIZE(12), .BASE_ADDR(12'hFFF)) dut_b (
        .clk(clk), .reset(reset), .load_start(load_start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .busy(busy_b), .done(done_b),
        .error(error_b), .cpu_rst_n(cpu_rst_n_b), .words_loaded(words_loaded_b));

    always #5 clk = ~clk;

    int cmp_count = 0;
    int err_count = 0;

    // Expected writes: word offset from BASE_ADDR and data, in order.
    int          exp_off [64];
    logic [31:0] exp_dat [64];
    int          exp_wr = 0;
    int          exp_rd = 0;
    int          writes_seen = 0;
    int          wl_base = 0;
    bit          chk_en = 1'b0;
    logic        rst_at_edge = 1'b0;
    logic [31:0] last_wdata = '0;
    logic [11:0] last_addr_a = '0;
    logic [11:0] last_addr_b = '0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] xor32(input logic [31:0] d);
        return d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    endfunction

    always @(posedge clk) rst_at_edge <= !reset;

    always @(negedge clk) begin
        if (chk_en) begin
            if (rst_at_edge) begin
                last_wdata  = '0;
                last_addr_a = '0;
                last_addr_b = '0;
            end
            check("cpu_rst_n_follows_done", {63'd0, cpu_rst_n_a}, {63'd0, done_a});
            check("busy_excl", {63'd0, busy_a & (done_a | error_a)}, 64'd0);
            check("words_loaded_a", 64'(words_loaded_a), 64'(writes_seen - wl_base));
            check("words_loaded_b", 64'(words_loaded_b), 64'(writes_seen - wl_base));
            check("we_b_eq_model", {63'd0, mem_we_b}, {63'd0, mem_we_a});
            if (mem_we_a) begin
                check("ready_low_in_write", {63'd0, rx_ready_a}, 64'd0);
                if (exp_rd >= exp_wr) begin
                    cmp_count++;
                    err_count++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", mem_addr_a, mem_wdata_a);
                end else begin
                    check("write_addr_a", 64'(mem_addr_a), 64'((exp_off[exp_rd]) % 4096));
                    check("write_addr_b", 64'(mem_addr_b), 64'((4095 + exp_off[exp_rd]) % 4096));
                    check("write_data_a", 64'(mem_wdata_a), 64'(exp_dat[exp_rd]));
                    check("write_data_b", 64'(mem_wdata_b), 64'(exp_dat[exp_rd]));
                    exp_rd++;
                end
                last_wdata  = mem_wdata_a;
                last_addr_a = mem_addr_a;
                last_addr_b = mem_addr_b;
                writes_seen++;
            end else begin
                check("wdata_hold", 64'(mem_wdata_a), 64'(last_wdata));
                check("addr_hold_a", 64'(mem_addr_a), 64'(last_addr_a));
                check("addr_hold_b", 64'(mem_addr_b), 64'(last_addr_b));
            end
        end
    end

    task automatic push_word(input int off, input logic [31:0] d);
        exp_off[exp_wr] = off;
        exp_dat[exp_wr] = d;
        exp_wr++;
    endtask

    task automatic pulse_start(input bit counted);
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        if (counted) wl_base = writes_seen;
    endtask

    // Present one byte and hold it until accepted; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            cmp_count++;
            err_count++;
            $display("FAIL byte_timeout: rx_ready stayed 0 for byte 0x%0h, required 1", b);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input bit rnd);
        for (int i = 0; i < 4; i++)
            send_byte(d[31-8*i -: 8], rnd ? int'($urandom_range(0, 2)) : 0);
    endtask

    // Wraps up a load after its last data byte: trailer (if any) then the cycle where done shows.
    task automatic finish_load(input logic [7:0] chk);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(chk, 0);
        @(negedge clk);
`else
        if (chk === 8'hxx) $display("unreachable");
        @(negedge clk);
        @(negedge clk);
`endif
    endtask

    task automatic check_status(input string tag, input bit exp_done, input bit exp_err, input int exp_words);
        check({tag, "_done"},      {63'd0, done_a},      {63'd0, exp_done});
        check({tag, "_error"},     {63'd0, error_a},     {63'd0, exp_err});
        check({tag, "_cpu_rst_n"}, {63'd0, cpu_rst_n_a}, {63'd0, exp_done});
        check({tag, "_busy"},      {63'd0, busy_a},      64'd0);
        check({tag, "_rx_ready"},  {63'd0, rx_ready_a},  64'd0);
        check({tag, "_words"},     64'(words_loaded_a),  64'(exp_words));
        check({tag, "_writes_all_seen"}, 64'(exp_rd), 64'(exp_wr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_ready"},  {63'd0, rx_ready_a},  64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr_a),      64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata_a),     64'd0);
        check({tag, "_mem_we"},    {63'd0, mem_we_a},    64'd0);
        check({tag, "_busy"},      {63'd0, busy_a},      64'd0);
        check({tag, "_done"},      {63'd0, done_a},      64'd0);
        check({tag, "_error"},     {63'd0, error_a},     64'd0);
        check({tag, "_cpu_rst_n"}, {63'd0, cpu_rst_n_a}, 64'd0);
        check({tag, "_words"},     64'(words_loaded_a),  64'd0);
        check({tag, "_addr_b"},    64'(mem_addr_b),      64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] x;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        chk_en = 1'b1;

        // Basic load: two words
        push_word(0, 32'h28005001);
        push_word(1, 32'h90000000);
        pulse_start(1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'h28005001, 0);
        send_word(32'h90000000, 0);
        finish_load(8'hE9);
        check_status("basic", 1'b1, 1'b0, 2);
        check("basic_wdata_literal", 64'(mem_wdata_a), 64'h90000000);
        check("basic_addr_b_literal", 64'(mem_addr_b), 64'h000);

        // Zero length
        pulse_start(1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        @(negedge clk);
        check_status("zero_len", 1'b1, 1'b0, 0);

        // Oversize header (N = MEMSIZE+1)
        pulse_start(1);
        send_byte(8'h10, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        check_status("oversize", 1'b0, 1'b1, 0);

        // Wrap (instance b at 0xFFF) with random backpressure
        push_word(0, 32'hA1B2C3D4);
        push_word(1, 32'h0F1E2D3C);
        pulse_start(1);
        send_byte(8'h00, 1);
        send_byte(8'h02, 2);
        send_word(32'hA1B2C3D4, 1);
        send_word(32'h0F1E2D3C, 1);
        finish_load(xor32(32'hA1B2C3D4) ^ xor32(32'h0F1E2D3C));
        check_status("wrap", 1'b1, 1'b0, 2);

        // Reset mid-load after 2 of 4 data bytes
        pulse_start(1);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        wl_base = writes_seen;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b1;
        push_word(0, 32'hDEADBEEF);
        pulse_start(1);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'hDEADBEEF, 0);
        finish_load(xor32(32'hDEADBEEF));
        check_status("after_reset", 1'b1, 1'b0, 1);

        // load_start ignored during DATA, then restart after DONE
        push_word(0, 32'h11223344);
        push_word(1, 32'h55667788);
        pulse_start(1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        pulse_start(0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_word(32'h55667788, 0);
        finish_load(xor32(32'h11223344) ^ xor32(32'h55667788));
        check_status("busy_ignore", 1'b1, 1'b0, 2);
        pulse_start(1);
        @(negedge clk);
        check("restart_done", {63'd0, done_a}, 64'd0);
        check("restart_cpu_rst_n", {63'd0, cpu_rst_n_a}, 64'd0);
        check("restart_words", 64'(words_loaded_a), 64'd0);
        check("restart_busy", {63'd0, busy_a}, 64'd1);
        push_word(0, 32'hCAFEF00D);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'hCAFEF00D, 0);
        finish_load(xor32(32'hCAFEF00D));
        check_status("second_load", 1'b1, 1'b0, 1);

`ifdef PROG_LOADER_CHECKSUM_EN
        for (int k = 0; k < 2; k++) begin
            x = (k == 0) ? 8'h08 : 8'h09;
            push_word(0, 32'h12345678);
            pulse_start(1);
            send_byte(8'h00, 0);
            send_byte(8'h01, 0);
            send_word(32'h12345678, 0);
            send_byte(x, 0);
            @(negedge clk);
            check_status(k == 0 ? "chk_good" : "chk_bad", k == 0, k != 0, 1);
        end
`else
        x = 8'h00;
        check("no_trailer_idle_ready", {56'd0, x}, {63'd0, rx_ready_a});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end
endmodule
